multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/arm_ctrl_pkg.sv | 80 ++++++++
 rtl/multicycle_controller_cond_check.sv | 69 ++++++
 rtl/multicycle_controller.sv | 179 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_ctrl_pkg.sv
// Shared definitions for the multicycle ARM-subset controller.
// Holds the FSM state enum, mux-select / immediate-format encodings,
// the ALU control encoding, the data-processing command decode and
// the ARM condition codes.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXECR,
        EXECI,
        ALUWB,
        BRANCH
    } state_t;

    // Immediate extender formats
    localparam logic [1:0] IMM_DP  = 2'b00;  // 8-bit zero-extend
    localparam logic [1:0] IMM_MEM = 2'b01;  // 12-bit LDR/STR offset
    localparam logic [1:0] IMM_BR  = 2'b10;  // 24-bit branch offset

    // Result mux selects
    localparam logic [1:0] RES_ALUOUT = 2'b00;  // registered ALU result
    localparam logic [1:0] RES_DATA   = 2'b01;  // memory read data
    localparam logic [1:0] RES_ALU    = 2'b10;  // live ALU result

    // ALU operand B selects
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_EXT  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // ALU control
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    // Data-processing command field funct[4:1]
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    // ARM condition codes
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    // Unknown commands fall back to ADD
    function automatic logic [1:0] alu_decode(input logic [3:0] cmd);
        case (cmd)
            CMD_ADD: alu_decode = ALU_ADD;
            CMD_SUB: alu_decode = ALU_SUB;
            CMD_AND: alu_decode = ALU_AND;
            CMD_ORR: alu_decode = ALU_ORR;
            default: alu_decode = ALU_ADD;
        endcase
    endfunction

    // Only arithmetic ops produce meaningful carry/overflow
    function automatic logic is_arith(input logic [3:0] cmd);
        is_arith = (cmd == CMD_ADD) || (cmd == CMD_SUB);
    endfunction

endpackage

// File: rtl/multicycle_controller_cond_check.sv
// Condition evaluation and NZCV flag storage.
// Ports:
//   clk, reset          - clock, synchronous active-high reset (clears NZCV)
//   cond[3:0]           - instruction condition field
//   alu_flags[3:0]      - NZCV from the ALU this cycle
//   nz_we, cv_we        - load enables for the N/Z and C/V flag pairs
//   cond_ex             - condition passes against the stored flags
//   flags[3:0]          - stored NZCV
module cond_check
    import arm_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic       nz_we,
    input  logic       cv_we,
    output logic       cond_ex,
    output logic [3:0] flags
);

    logic [3:0] flags_reg;
    logic [3:0] flags_next;
    logic [3:0] bit_we;
    logic       n, z, c, v;

    // Bit order is N,Z,C,V from msb to lsb
    assign bit_we = {nz_we, nz_we, cv_we, cv_we};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_flag
            assign flags_next[gi] = bit_we[gi] ? alu_flags[gi] : flags_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_reg <= 4'b0000;
        end else begin
            flags_reg <= flags_next;
        end
    end

    assign {n, z, c, v} = flags_reg;
    assign flags        = flags_reg;

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;  // 1111 is never executed
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset control unit: FSM sequencing plus datapath
// enable / mux-select decode. Condition checking and NZCV storage live
// in cond_check.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   Instr[31:12]      - cond, op, funct, Rn, Rd fields of the held IR
//   ALUFlags[3:0]     - NZCV from the ALU this cycle
//   PCWrite, IRWrite, MemWrite, RegWrite - write enables
//   AdrSrc, ALUSrcA   - 1-bit mux selects
//   ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl - 2-bit selects
module multicycle_controller
    import arm_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [31:12] Instr,
    input  logic [3:0]   ALUFlags,
    output logic         PCWrite,
    output logic         IRWrite,
    output logic         MemWrite,
    output logic         RegWrite,
    output logic         AdrSrc,
    output logic         ALUSrcA,
    output logic [1:0]   ResultSrc,
    output logic [1:0]   ALUSrcB,
    output logic [1:0]   ImmSrc,
    output logic [1:0]   RegSrc,
    output logic [1:0]   ALUControl
);

    state_t     state_reg;
    state_t     state_next;
    state_t     out_state;

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [1:0] alu_dec;
    logic       cond_ex;
    logic       in_exec;
    logic       nz_we;
    logic       cv_we;
    logic [3:0] flags;
    logic       unused_bits;

    assign cond  = Instr[31:28];
    assign op    = Instr[27:26];
    assign funct = Instr[25:20];
    assign rd    = Instr[15:12];

    // Rn is a datapath concern only; flags are observed internally.
    assign unused_bits = ^{Instr[19:16], flags};

    assign alu_dec = alu_decode(funct[4:1]);

    // Flags load on the edge that ends an execute state when S is set
    // and the instruction actually executes.
    assign in_exec = (state_reg == EXECR) || (state_reg == EXECI);
    assign nz_we   = in_exec & funct[0] & cond_ex & ~reset;
    assign cv_we   = nz_we & is_arith(funct[4:1]);

    cond_check u_cond (
        .clk       (clk),
        .reset     (reset),
        .cond      (cond),
        .alu_flags (ALUFlags),
        .nz_we     (nz_we),
        .cv_we     (cv_we),
        .cond_ex   (cond_ex),
        .flags     (flags)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FETCH:  state_next = DECODE;
            DECODE: begin
                case (op)
                    2'b01:   state_next = MEMADR;
                    2'b00:   state_next = funct[5] ? EXECI : EXECR;
                    2'b10:   state_next = BRANCH;
                    default: state_next = FETCH;  // unsupported op is a NOP
                endcase
            end
            MEMADR: state_next = funct[0] ? MEMRD : MEMWR;
            MEMRD:  state_next = MEMWB;
            EXECR:  state_next = ALUWB;
            EXECI:  state_next = ALUWB;
            default: state_next = FETCH;
        endcase
    end

    // While reset is held the outputs look like FETCH with its enables
    // suppressed, so an aborted instruction cannot write on the reset edge.
    assign out_state = reset ? FETCH : state_reg;

    // Output decode
    always_comb begin
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcB    = SRCB_REG;
        ImmSrc     = IMM_DP;
        RegSrc     = 2'b00;
        ALUControl = ALU_ADD;
        case (out_state)
            FETCH: begin
                PCWrite   = ~reset;
                IRWrite   = ~reset;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
            end
            MEMADR: begin
                ALUSrcB   = SRCB_EXT;
                ImmSrc    = IMM_MEM;
                RegSrc[1] = ~funct[0];
            end
            MEMRD: begin
                AdrSrc    = 1'b1;
                ResultSrc = RES_ALUOUT;
            end
            MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = cond_ex;
            end
            MEMWR: begin
                AdrSrc    = 1'b1;
                ResultSrc = RES_ALUOUT;
                MemWrite  = cond_ex;
                RegSrc[1] = ~funct[0];
            end
            EXECR: begin
                ALUSrcB    = SRCB_REG;
                ALUControl = alu_dec;
            end
            EXECI: begin
                ALUSrcB    = SRCB_EXT;
                ImmSrc     = IMM_DP;
                ALUControl = alu_dec;
            end
            ALUWB: begin
                ResultSrc = RES_ALUOUT;
                RegWrite  = cond_ex;
                PCWrite   = cond_ex & (rd == 4'b1111);
            end
            BRANCH: begin
                ALUSrcB   = SRCB_EXT;
                ImmSrc    = IMM_BR;
                ResultSrc = RES_ALU;
                RegSrc[0] = 1'b1;
                PCWrite   = cond_ex;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: the driver pushes the
// hand-computed output vector for each cycle, a monitor pops and
// compares mid-cycle.
module tb_multicycle_controller;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [31:12] Instr = '0;
    logic [3:0]   ALUFlags = '0;
    logic         PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA;
    logic [1:0]   ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [15:0] out;
        bit          chkf;
        logic [3:0]  flags;
        string       name;
    } exp_t;

    exp_t q[$];

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .IRWrite    (IRWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .AdrSrc     (AdrSrc),
        .ALUSrcA    (ALUSrcA),
        .ResultSrc  (ResultSrc),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .ALUControl (ALUControl)
    );

    always #5 clk = ~clk;

    // {PCWrite,IRWrite,MemWrite,RegWrite,AdrSrc,ALUSrcA,ResultSrc,ALUSrcB,ImmSrc,RegSrc,ALUControl}
    function automatic logic [15:0] e(input bit pcw, input bit irw, input bit mw, input bit rw,
                                      input bit adr, input bit asa, input logic [1:0] rs,
                                      input logic [1:0] asb, input logic [1:0] imm,
                                      input logic [1:0] rsrc, input logic [1:0] alu);
        return {pcw, irw, mw, rw, adr, asa, rs, asb, imm, rsrc, alu};
    endfunction

    function automatic logic [19:0] mk(input logic [3:0] c, input logic [1:0] op,
                                       input logic [5:0] f, input logic [3:0] rd);
        return {c, op, f, 4'h2, rd};
    endfunction

    logic [15:0] FETCH_V, DEC_V, RST_V, MADR_LD, MADR_ST, MRD_V, MWB_V, MWR_V;

    function automatic logic [15:0] execi(input logic [1:0] alu);
        return e(0,0,0,0,0,0,2'd0,2'd1,2'd0,2'd0,alu);
    endfunction
    function automatic logic [15:0] execr(input logic [1:0] alu);
        return e(0,0,0,0,0,0,2'd0,2'd0,2'd0,2'd0,alu);
    endfunction
    function automatic logic [15:0] aluwb(input bit rw, input bit pcw);
        return e(pcw,0,0,rw,0,0,2'd0,2'd0,2'd0,2'd0,2'd0);
    endfunction
    function automatic logic [15:0] branch(input bit pcw);
        return e(pcw,0,0,0,0,0,2'd2,2'd1,2'd2,2'd1,2'd0);
    endfunction

    // One clock of stimulus: drive just after the edge, queue what the
    // outputs must be for the rest of that cycle.
    task automatic cyc(input logic [19:0] ins, input logic [3:0] fl, input logic rst,
                       input logic [15:0] out, input string name,
                       input bit chkf, input logic [3:0] f);
        exp_t x;
        @(posedge clk);
        #1;
        Instr    = ins;
        ALUFlags = fl;
        reset    = rst;
        x.out = out; x.chkf = chkf; x.flags = f; x.name = name;
        q.push_back(x);
    endtask

    task automatic c0(input logic [19:0] ins, input logic [3:0] fl,
                      input logic [15:0] out, input string name);
        cyc(ins, fl, 1'b0, out, name, 1'b0, 4'h0);
    endtask

    // Monitor
    initial begin
        exp_t x;
        logic [15:0] act;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                x = q.pop_front();
                act = {PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA,
                       ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl};
                tests++;
                if (act !== x.out) begin
                    fails++;
                    $display("FAIL %s: outputs got %h required %h", x.name, act, x.out);
                end else begin
                    $display("[TB] %s outputs %h ok", x.name, act);
                end
                if (x.chkf) begin
                    tests++;
                    if (dut.u_cond.flags_reg !== x.flags) begin
                        fails++;
                        $display("FAIL %s.flags: got %b required %b", x.name,
                                 dut.u_cond.flags_reg, x.flags);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [19:0] junk, addi, ldr, str, subs, beq, bne, addne, addpc;
        FETCH_V = e(1,1,0,0,0,1,2'd2,2'd2,2'd0,2'd0,2'd0);
        DEC_V   = e(0,0,0,0,0,1,2'd2,2'd2,2'd0,2'd0,2'd0);
        RST_V   = DEC_V;
        MADR_LD = e(0,0,0,0,0,0,2'd0,2'd1,2'd1,2'd0,2'd0);
        MADR_ST = e(0,0,0,0,0,0,2'd0,2'd1,2'd1,2'd2,2'd0);
        MRD_V   = e(0,0,0,0,1,0,2'd0,2'd0,2'd0,2'd0,2'd0);
        MWB_V   = e(0,0,0,1,0,0,2'd1,2'd0,2'd0,2'd0,2'd0);
        MWR_V   = e(0,0,1,0,1,0,2'd0,2'd0,2'd0,2'd2,2'd0);

        junk  = 20'hFFFFF;
        addi  = mk(4'hE, 2'b00, 6'b101000, 4'h1);
        ldr   = mk(4'hE, 2'b01, 6'b011001, 4'h3);
        str   = mk(4'hE, 2'b01, 6'b011000, 4'h3);
        subs  = mk(4'hE, 2'b00, 6'b000101, 4'h2);
        beq   = mk(4'h0, 2'b10, 6'b000000, 4'h0);
        bne   = mk(4'h1, 2'b10, 6'b000000, 4'h0);
        addne = mk(4'h1, 2'b00, 6'b001001, 4'hF);
        addpc = mk(4'hE, 2'b00, 6'b001000, 4'hF);

        // Reset held
        cyc(junk, 4'h0, 1'b1, RST_V, "rst0", 1'b0, 4'h0);
        cyc(junk, 4'h0, 1'b1, RST_V, "rst1", 1'b1, 4'h0);

        // ADD R1,R2,#5; IR contents during FETCH must not matter
        c0(junk, 4'h0, FETCH_V,    "add.fetch");
        c0(addi, 4'h0, DEC_V,      "add.decode");
        c0(addi, 4'h0, execi(2'd0), "add.execi");
        c0(addi, 4'h0, aluwb(1,0), "add.aluwb");

        // LDR
        c0(ldr, 4'h0, FETCH_V, "ldr.fetch");
        c0(ldr, 4'h0, DEC_V,   "ldr.decode");
        c0(ldr, 4'h0, MADR_LD, "ldr.memadr");
        c0(ldr, 4'h0, MRD_V,   "ldr.memrd");
        c0(ldr, 4'h0, MWB_V,   "ldr.memwb");

        // STR
        c0(str, 4'h0, FETCH_V, "str.fetch");
        c0(str, 4'h0, DEC_V,   "str.decode");
        c0(str, 4'h0, MADR_ST, "str.memadr");
        c0(str, 4'h0, MWR_V,   "str.memwr");

        // SUBS with Z from the ALU
        c0(subs, 4'h4, FETCH_V,     "subs.fetch");
        c0(subs, 4'h4, DEC_V,       "subs.decode");
        c0(subs, 4'h4, execr(2'd1), "subs.execr");
        cyc(subs, 4'h0, 1'b0, aluwb(1,0), "subs.aluwb", 1'b1, 4'b0100);

        // BEQ taken, BNE not taken
        c0(beq, 4'h0, FETCH_V,   "beq.fetch");
        c0(beq, 4'h0, DEC_V,     "beq.decode");
        c0(beq, 4'h0, branch(1), "beq.branch");
        c0(bne, 4'h0, FETCH_V,   "bne.fetch");
        c0(bne, 4'h0, DEC_V,     "bne.decode");
        c0(bne, 4'h0, branch(0), "bne.branch");

        // ADDNE S=1 Rd=PC with Z set: no writes, flags kept
        c0(addne, 4'hB, FETCH_V,     "addne.fetch");
        c0(addne, 4'hB, DEC_V,       "addne.decode");
        c0(addne, 4'hB, execr(2'd0), "addne.execr");
        cyc(addne, 4'h0, 1'b0, aluwb(0,0), "addne.aluwb", 1'b1, 4'b0100);
        c0(beq, 4'h0, FETCH_V,   "beq2.fetch");
        c0(beq, 4'h0, DEC_V,     "beq2.decode");
        c0(beq, 4'h0, branch(1), "beq2.branch");

        // ADD to PC, always
        c0(addpc, 4'h0, FETCH_V,     "addpc.fetch");
        c0(addpc, 4'h0, DEC_V,       "addpc.decode");
        c0(addpc, 4'h0, execr(2'd0), "addpc.execr");
        c0(addpc, 4'h0, aluwb(1,1),  "addpc.aluwb");

        // ALU command decode: AND, ORR, other (MOV) -> ADD
        begin
            logic [5:0]  fv [3];
            logic [1:0]  av [3];
            fv[0] = 6'b100000; av[0] = 2'd2;
            fv[1] = 6'b111000; av[1] = 2'd3;
            fv[2] = 6'b111010; av[2] = 2'd0;
            for (int i = 0; i < 3; i++) begin
                logic [19:0] ins;
                ins = mk(4'hE, 2'b00, fv[i], 4'h5);
                c0(ins, 4'h0, FETCH_V,      $sformatf("dp%0d.fetch", i));
                c0(ins, 4'h0, DEC_V,        $sformatf("dp%0d.decode", i));
                c0(ins, 4'h0, execi(av[i]), $sformatf("dp%0d.execi", i));
                c0(ins, 4'h0, aluwb(1,0),   $sformatf("dp%0d.aluwb", i));
            end
        end

        // ADDS loads all of NZCV = 0011
        begin
            logic [19:0] adds, ands, subsgt, addnv;
            adds   = mk(4'hE, 2'b00, 6'b101001, 4'h4);
            ands   = mk(4'hE, 2'b00, 6'b000001, 4'h4);
            subsgt = mk(4'hC, 2'b00, 6'b000101, 4'h4);
            addnv  = mk(4'hF, 2'b00, 6'b101000, 4'h1);
            c0(adds, 4'h3, FETCH_V,     "adds.fetch");
            c0(adds, 4'h3, DEC_V,       "adds.decode");
            c0(adds, 4'h3, execi(2'd0), "adds.execi");
            cyc(adds, 4'h0, 1'b0, aluwb(1,0), "adds.aluwb", 1'b1, 4'b0011);
            // ANDS loads NZ only: 11 from ALU, CV keep 11
            c0(ands, 4'hC, FETCH_V,     "ands.fetch");
            c0(ands, 4'hC, DEC_V,       "ands.decode");
            c0(ands, 4'hC, execr(2'd2), "ands.execr");
            cyc(ands, 4'h0, 1'b0, aluwb(1,0), "ands.aluwb", 1'b1, 4'b1111);
            // SUBSGT with Z set fails: nothing written, flags kept
            c0(subsgt, 4'h0, FETCH_V,     "subsgt.fetch");
            c0(subsgt, 4'h0, DEC_V,       "subsgt.decode");
            c0(subsgt, 4'h0, execr(2'd1), "subsgt.execr");
            cyc(subsgt, 4'h0, 1'b0, aluwb(0,0), "subsgt.aluwb", 1'b1, 4'b1111);
            // cond=1111 never executes
            c0(addnv, 4'h0, FETCH_V,     "nv.fetch");
            c0(addnv, 4'h0, DEC_V,       "nv.decode");
            c0(addnv, 4'h0, execi(2'd0), "nv.execi");
            c0(addnv, 4'h0, aluwb(0,0),  "nv.aluwb");
        end

        // Reset during MEMWR: no MemWrite, back to FETCH with flags cleared
        c0(str, 4'h0, FETCH_V, "strr.fetch");
        c0(str, 4'h0, DEC_V,   "strr.decode");
        c0(str, 4'h0, MADR_ST, "strr.memadr");
        cyc(str, 4'h0, 1'b1, RST_V, "strr.memwr_reset", 1'b1, 4'b1111);
        cyc(str, 4'h0, 1'b0, FETCH_V, "post_reset.fetch", 1'b1, 4'b0000);

        // Unsupported op=11 returns to FETCH without writes
        c0(mk(4'hE, 2'b11, 6'b000000, 4'h1), 4'h0, DEC_V, "op11.decode");
        c0(mk(4'hE, 2'b11, 6'b000000, 4'h1), 4'h0, FETCH_V, "op11.fetch");

        repeat (3) @(posedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
